// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mult_pkg;

   localparam int unsigned MULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      NOP = 2'b00,
      ADD = 2'b01,
      SUB = 2'b10
   } booth_e;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Request/response bundle between the execute stage and mult_seq.
interface mult_seq_if
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH
);

   logic             ctrl_MULT;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_MULT, data_operandA, data_operandB,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  ctrl_MULT, data_operandA, data_operandB,
      output data_result, data_exception, data_resultRDY, busy
   );

endinterface

// File: rtl/cla32.sv
// Two-level carry-lookahead adder: 8-bit lookahead slices joined by group P/G lookahead.
module cla8 (
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       gp,
   output logic       gg
);

   logic [7:0] g;
   logic [7:0] p;
   logic [7:0] c;

   assign g = x & y;
   assign p = x ^ y;

   always_comb begin
      c    = '0;
      c[0] = cin;
      for (int unsigned k = 0; k < 7; k++) begin
         c[k+1] = g[k] | (p[k] & c[k]);
      end
   end

   // Group generate kept in its own process so it carries no dependency on cin.
   always_comb begin
      gg = 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
         gg = g[k] | (p[k] & gg);
      end
   end

   assign sum = p ^ c;
   assign gp  = &p;

endmodule

module cla32
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NG = WIDTH / 8;

   logic [NG-1:0] gp;
   logic [NG-1:0] gg;
   logic [NG:0]   gc;

   for (genvar i = 0; i < NG; i++) begin : g_slice
      cla8 u_slice (
         .x   (x[8*i +: 8]),
         .y   (y[8*i +: 8]),
         .cin (gc[i]),
         .sum (sum[8*i +: 8]),
         .gp  (gp[i]),
         .gg  (gg[i])
      );
   end

   always_comb begin
      gc    = '0;
      gc[0] = cin;
      for (int unsigned i = 0; i < NG; i++) begin
         gc[i+1] = gg[i] | (gp[i] & gc[i]);
      end
   end

   assign cout = gc[NG];
   assign ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/mult_seq.sv
// Sequential signed radix-2 Booth multiplier, WIDTH iterations per product.
// Define MULT_OVF_DETECT_EN to flag products that do not fit in WIDTH signed bits.
module mult_seq
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH
) (
   input  logic     clock,
   input  logic     reset_n,
   mult_seq_if.slave bus
);

   localparam int unsigned CW = cnt_width(WIDTH);
   localparam int unsigned PW = 2 * WIDTH + 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             exc_q, exc_d;

   booth_e           op;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] add_y;
   logic             add_cin;
   logic [WIDTH-1:0] sum;
   logic             add_ovf;
   logic             cout_unused;
   logic [PW-1:0]    shifted;
   logic             ovf_flag;

   assign acc = prod_q[PW-1:WIDTH+1];

   always_comb begin
      op      = NOP;
      add_y   = '0;
      add_cin = 1'b0;
      case (prod_q[1:0])
         2'b01: begin
            op    = ADD;
            add_y = mcand_q;
         end
         2'b10: begin
            op      = SUB;
            add_y   = ~mcand_q;
            add_cin = 1'b1;
         end
         default: op = NOP;
      endcase
   end

   cla32 #(.WIDTH(WIDTH)) u_cla (
      .x    (acc),
      .y    (add_y),
      .cin  (add_cin),
      .sum  (sum),
      .cout (cout_unused),
      .ovf  (add_ovf)
   );

   // Shifted-in sign is the true sign of the (WIDTH+1)-bit sum, so mcand = -2^(WIDTH-1) stays exact.
   assign shifted = {sum[WIDTH-1] ^ add_ovf, sum, prod_q[WIDTH:1]};

`ifdef MULT_OVF_DETECT_EN
   assign ovf_flag = !((&shifted[PW-1:WIDTH]) || !(|shifted[PW-1:WIDTH]));
`else
   assign ovf_flag = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      count_d  = count_q;
      result_d = result_q;
      exc_d    = exc_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.ctrl_MULT) begin
               state_d = RUN;
               mcand_d = bus.data_operandA;
               prod_d  = {WIDTH'(0), bus.data_operandB, 1'b0};
               count_d = '0;
            end
         end
         RUN: begin
            if (bus.ctrl_MULT) begin
               mcand_d = bus.data_operandA;
               prod_d  = {WIDTH'(0), bus.data_operandB, 1'b0};
               count_d = '0;
            end else begin
               prod_d  = shifted;
               count_d = count_q + CW'(1);
               if (count_q == CW'(WIDTH - 1)) begin
                  state_d  = DONE;
                  result_d = shifted[WIDTH:1];
                  exc_d    = ovf_flag;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         prod_q   <= '0;
         count_q  <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         count_q  <= count_d;
         result_q <= result_d;
         exc_q    <= exc_d;
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = (state_q == DONE);
   assign bus.busy           = (state_q == RUN);

endmodule

// File: tb/tb_mult_seq.sv
// Directed-vector bench for mult_seq: products, latency, restart, reset and DONE-cycle restart.
module tb_mult_seq;
   import mult_pkg::*;

`ifdef MULT_OVF_DETECT_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   rdy_cnt;

   mult_seq_if #(.WIDTH(32)) bus ();

   mult_seq #(.WIDTH(32)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rdy_cnt <= rdy_cnt + int'(bus.data_resultRDY);

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      bus.ctrl_MULT     = 1'b1;
      bus.data_operandA = a;
      bus.data_operandB = b;
      @(negedge clk);
      bus.ctrl_MULT     = 1'b0;
   endtask

   task automatic wait_rdy(output int lat);
      lat = 0;
      while (!bus.data_resultRDY && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.data_resultRDY) lat = -1;
   endtask

   task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic exc);
      int lat;
      start_op(a, b);
      check_val({tag, "_busy"}, 64'(bus.busy), 64'(1));
      wait_rdy(lat);
      check_val({tag, "_lat"}, 64'(lat), 64'(32));
      check_val({tag, "_res"}, 64'(bus.data_result), 64'(res));
      check_val({tag, "_exc"}, 64'(bus.data_exception), 64'(exc & OVF_EN));
      @(negedge clk);
      check_val({tag, "_pulse"}, 64'(bus.data_resultRDY), 64'(0));
      check_val({tag, "_hold"}, 64'(bus.data_result), 64'(res));
   endtask

   initial begin
      int lat;
      int cnt0;
      n_checks          = 0;
      n_errors          = 0;
      rdy_cnt           = 0;
      rst_n             = 1'b0;
      bus.ctrl_MULT     = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      repeat (3) @(negedge clk);
      check_val("rst_res", 64'(bus.data_result), 64'(0));
      check_val("rst_exc", 64'(bus.data_exception), 64'(0));
      check_val("rst_rdy", 64'(bus.data_resultRDY), 64'(0));
      check_val("rst_busy", 64'(bus.busy), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      do_mult("m3x5",      32'd3,          32'd5,          32'h0000000F, 1'b0);
      do_mult("mneg7x6",   32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6, 1'b0);
      do_mult("m0xff",     32'd0,          32'hFFFFFFFF,   32'h00000000, 1'b0);
      do_mult("mminxm1",   32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1);
      do_mult("mminx1",    32'h80000000,   32'd1,          32'h80000000, 1'b0);
      do_mult("m2p16sq",   32'h00010000,   32'h00010000,   32'h00000000, 1'b1);
      do_mult("mm1xm1",    32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 1'b0);
      do_mult("mminsq",    32'h80000000,   32'h80000000,   32'h00000000, 1'b1);
      do_mult("mmaxx2",    32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE, 1'b1);

      // Restart 10 cycles into RUN: only the second operation completes.
      cnt0 = rdy_cnt;
      start_op(32'd100, 32'd7);
      repeat (10) @(negedge clk);
      check_val("rs_mid_busy", 64'(bus.busy), 64'(1));
      do_mult("rs2x3", 32'd2, 32'd3, 32'd6, 1'b0);
      check_val("rs_one_rdy", 64'(rdy_cnt - cnt0), 64'(1));

      // Reset during RUN.
      start_op(32'd9, 32'd9);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_val("mr_res", 64'(bus.data_result), 64'(0));
      check_val("mr_exc", 64'(bus.data_exception), 64'(0));
      check_val("mr_busy", 64'(bus.busy), 64'(0));
      check_val("mr_rdy", 64'(bus.data_resultRDY), 64'(0));
      check_val("mr_state", 64'(dut.state_q), 64'(IDLE));
      rst_n = 1'b1;
      cnt0  = rdy_cnt;
      repeat (40) @(negedge clk);
      check_val("mr_no_rdy", 64'(rdy_cnt - cnt0), 64'(0));
      do_mult("mrm3xm4", 32'hFFFFFFFD, 32'hFFFFFFFC, 32'd12, 1'b0);

      // Restart issued in the DONE cycle: RDY still pulses, new op loads on that edge.
      start_op(32'd3, 32'd5);
      wait_rdy(lat);
      check_val("dn_lat1", 64'(lat), 64'(32));
      check_val("dn_res1", 64'(bus.data_result), 64'(15));
      start_op(32'd6, 32'd7);
      check_val("dn_rdy_off", 64'(bus.data_resultRDY), 64'(0));
      check_val("dn_busy", 64'(bus.busy), 64'(1));
      check_val("dn_hold", 64'(bus.data_result), 64'(15));
      wait_rdy(lat);
      check_val("dn_lat2", 64'(lat), 64'(32));
      check_val("dn_res2", 64'(bus.data_result), 64'(42));
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mult_seq.md
# mult_seq

Sequential signed 32×32 multiplier in the processor's execute stage, feeding operands each cycle into a 32-bit carry-lookahead adder built from four 8-bit lookahead slices joined by a second-level group-P/G lookahead. Radix-2 Booth recoding produces the low 32 bits of the signed product in a fixed 32 iterations. An optional overflow exception flags products that do not fit in 32 bits. It runs beside the single-cycle ALU; the pipeline stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand and result width; must be a multiple of 8, since the adder is tiled from 8-bit slices.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset; one clock, synchronous, active-low.
- `ctrl_MULT`  in  1  start pulse; operands sampled on the same edge.
- `data_operandA`  in  WIDTH  multiplicand, two's complement.
- `data_operandB`  in  WIDTH  multiplier, two's complement.
- `data_result`  out  WIDTH  low WIDTH bits of A×B; registered.
- `data_exception`  out  1  product not representable in WIDTH signed bits.
- `data_resultRDY`  out  1  one-cycle pulse: result and exception valid.
- `busy`  out  1  high while in RUN.

## Operation
- FSM states are IDLE, RUN and DONE.
- Registers:
  - `mcand` (WIDTH): latched A.
  - `prod` (2·WIDTH+1): holds {acc, mplier, booth bit}.
  - `count`: $clog2(WIDTH)+1 bits.
- Start (IDLE or DONE) with `ctrl_MULT`=1:
  - mcand←A; prod←{0, B, 1'b0}; count←0; go to RUN.
- RUN, per edge:
  - Recode `prod[1:0]`: 01 → acc+mcand; 10 → acc+~mcand with cin=1; 00/11 → acc unchanged (adder still computes acc+0).
  - Arithmetic right shift of {sum, prod[WIDTH:1]}.
  - The shifted-in MSB is `sum[WIDTH-1] XOR ovf`, where ovf is the signed overflow of that add. This keeps the partial product exact when mcand = −2^(WIDTH−1).
  - count←count+1. When count reaches WIDTH−1 (last iteration), go to DONE.
- Entering DONE:
  - data_result ← low WIDTH bits of the final product (`prod[WIDTH:1]` after the shift).
  - Exception computed from the full 2·WIDTH-bit product.
  - In DONE, data_resultRDY=1 for exactly one cycle; next state is IDLE unless `ctrl_MULT`=1.
- data_result and data_exception hold their values until the next DONE entry.
- `ctrl_MULT` in RUN aborts and restarts with the new operands; count←0; no RDY is produced for the aborted operation.
- `ctrl_MULT` in the DONE cycle: RDY still pulses and the restart loads on the same edge.
- Arithmetic is modulo 2^WIDTH on `data_result`; no saturation.

## Timing
- Reset values: all outputs 0, state IDLE, count 0, prod 0, mcand 0. `reset_n` low overrides `ctrl_MULT` on the same edge.
- Reset mid-RUN: the next edge returns to IDLE; no RDY pulse; outputs cleared.
- Sequence for `ctrl_MULT` sampled at edge N:
  - busy is high from N to N+WIDTH.
  - Edges N+1 … N+WIDTH perform the iterations.
  - data_resultRDY is high from N+WIDTH to N+WIDTH+1.
  - Latency is WIDTH cycles (32), start to RDY.
- Back-to-back throughput is one result per WIDTH+1 cycles.
- Critical path: the prod→adder→prod loop. It must close at the core clock with the two-level lookahead adder, with no extra register.

## Configuration
- `MULT_OVF_DETECT_EN` defined:
  - data_exception = 1 iff the upper WIDTH bits of the 2·WIDTH-bit product are not all equal to bit WIDTH−1 of the result.
  - Updated on DONE entry.
- `MULT_OVF_DETECT_EN` undefined: data_exception is tied to 0 and the upper-bit compare logic is removed; data_result is identical either way.

## Structure
- Package `mult_pkg`: state enum (IDLE, RUN, DONE), Booth recode constants (NOP, ADD, SUB), `WIDTH` default, and a count-width function.
- One sub-module, `cla32`: WIDTH/8 instances of the existing 8-bit lookahead slice, plus second-level carry logic over their group P/G.
  - Ports: x, y, cin, sum, cout, ovf.
- mult_seq holds only the FSM, registers and recode/shift logic.

## Test plan
- 3 × 5: result 0x0000000F, exception 0, RDY exactly 32 cycles after start, single pulse.
- −7 × 6: result 0xFFFFFFD6 (−42), exception 0; also 0 × 0xFFFFFFFF → 0.
- 0x80000000 × 0xFFFFFFFF: result 0x80000000, exception 1 with the macro and 0 without; 0x80000000 × 1 → 0x80000000, exception 0.
- 0x00010000 × 0x00010000: result 0x00000000, exception 1 (macro on).
- Restart at cycle 10 of RUN with 2 × 3: exactly one RDY, 32 cycles after the restart, result 6.
- `reset_n` low at cycle 20 of RUN: all outputs 0 on the next edge, state IDLE, no RDY; the next start completes normally.
